// File: rtl/bram_access_sched.sv
// Frame sequencer and data-port arbiter for a time-multiplexed block RAM.
// Runs a repeating 4-phase strobe frame (i1re, i2re, dre, gwe). It grants the
// single data slot of each frame to requester A or B, with round-robin on ties.
// It also routes the read data returned one frame-phase later to that requester.
//
// Handshake: a requester raises req with stable we/addr/wdata and holds it
// until its gnt pulses. gnt is a one-cycle pulse in P2. The request is sampled
// only on the P1->P2 edge, so one arriving later waits for the next frame.
// In the cycle after gnt the requester drops req or presents a new request.
// A read completes with a one-cycle rvalid two cycles after gnt.
// err pulses with the same timing for addresses 0 and 1, which are unbacked.
module bram_access_sched #(
    parameter int WORD_SIZE = 16
) (
    input  logic                 idclk,
    input  logic                 rst,
    input  logic                 run,
    input  logic                 a_req,
    input  logic                 a_we,
    input  logic [2:0]           a_addr,
    input  logic [WORD_SIZE-1:0] a_wdata,
    input  logic                 b_req,
    input  logic                 b_we,
    input  logic [2:0]           b_addr,
    input  logic [WORD_SIZE-1:0] b_wdata,
    output logic                 a_gnt,
    output logic                 b_gnt,
    output logic                 a_rvalid,
    output logic                 b_rvalid,
    output logic [WORD_SIZE-1:0] a_rdata,
    output logic [WORD_SIZE-1:0] b_rdata,
    output logic                 a_err,
    output logic                 b_err,
    output logic                 i1re,
    output logic                 i2re,
    output logic                 dre,
    output logic                 gwe,
    output logic [2:0]           draddr,
    output logic [2:0]           dwaddr,
    output logic [WORD_SIZE-1:0] din,
    output logic                 dwe,
    input  logic [WORD_SIZE-1:0] dout,
    output logic [1:0]           phase
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        P0   = 3'd1,
        P1   = 3'd2,
        P2   = 3'd3,
        P3   = 3'd4
    } state_t;

    state_t state_q, state_d;

    // Registered outputs and the pending-winner record
    logic                 i1re_q, i1re_d, i2re_q, i2re_d, dre_q, dre_d, gwe_q, gwe_d;
    logic [1:0]           phase_q, phase_d;
    logic                 a_gnt_q, a_gnt_d, b_gnt_q, b_gnt_d;
    logic [2:0]           addr_q, addr_d;
    logic [WORD_SIZE-1:0] din_q, din_d;
    logic                 dwe_q, dwe_d;
    logic                 a_rvalid_q, a_rvalid_d, b_rvalid_q, b_rvalid_d;
    logic                 a_err_q, a_err_d, b_err_q, b_err_d;
    logic [WORD_SIZE-1:0] a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;
    logic                 win_valid_q, win_valid_d, win_b_q, win_b_d;
    logic                 win_we_q, win_we_d, win_bad_q, win_bad_d;
    logic                 prefer_a_q, prefer_a_d;

    // Arbitration view of the current request inputs
    logic                 sel_valid, sel_b, sel_we, sel_bad;
    logic [2:0]           sel_addr;
    logic [WORD_SIZE-1:0] sel_wdata;
    logic                 arb_edge, ret_edge;

    // State register and all output/datapath registers; reset aborts any frame
    always_ff @(posedge idclk) begin
        if (!rst) begin
            state_q     <= IDLE;
            i1re_q      <= 1'b0;
            i2re_q      <= 1'b0;
            dre_q       <= 1'b0;
            gwe_q       <= 1'b0;
            phase_q     <= 2'd0;
            a_gnt_q     <= 1'b0;
            b_gnt_q     <= 1'b0;
            addr_q      <= 3'd0;
            din_q       <= '0;
            dwe_q       <= 1'b0;
            a_rvalid_q  <= 1'b0;
            b_rvalid_q  <= 1'b0;
            a_err_q     <= 1'b0;
            b_err_q     <= 1'b0;
            a_rdata_q   <= '0;
            b_rdata_q   <= '0;
            win_valid_q <= 1'b0;
            win_b_q     <= 1'b0;
            win_we_q    <= 1'b0;
            win_bad_q   <= 1'b0;
            prefer_a_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            i1re_q      <= i1re_d;
            i2re_q      <= i2re_d;
            dre_q       <= dre_d;
            gwe_q       <= gwe_d;
            phase_q     <= phase_d;
            a_gnt_q     <= a_gnt_d;
            b_gnt_q     <= b_gnt_d;
            addr_q      <= addr_d;
            din_q       <= din_d;
            dwe_q       <= dwe_d;
            a_rvalid_q  <= a_rvalid_d;
            b_rvalid_q  <= b_rvalid_d;
            a_err_q     <= a_err_d;
            b_err_q     <= b_err_d;
            a_rdata_q   <= a_rdata_d;
            b_rdata_q   <= b_rdata_d;
            win_valid_q <= win_valid_d;
            win_b_q     <= win_b_d;
            win_we_q    <= win_we_d;
            win_bad_q   <= win_bad_d;
            prefer_a_q  <= prefer_a_d;
        end
    end

    // Next-state: run is only looked at in IDLE and P3, so a started frame completes
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = run ? P0 : IDLE;
            P0:      state_d = P1;
            P1:      state_d = P2;
            P2:      state_d = P3;
            P3:      state_d = run ? P0 : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic: strobes, arbitration on the P1 edge, read return on the P3 edge
    always_comb begin
        arb_edge  = (state_q == P1);
        ret_edge  = (state_q == P3);

        // A tie goes to whichever requester was not granted last
        sel_valid = a_req | b_req;
        sel_b     = b_req & (~a_req | ~prefer_a_q);
        sel_we    = sel_b ? b_we    : a_we;
        sel_addr  = sel_b ? b_addr  : a_addr;
        sel_wdata = sel_b ? b_wdata : a_wdata;
        sel_bad   = (sel_addr < 3'd2);

        i1re_d  = (state_d == P0);
        i2re_d  = (state_d == P1);
        dre_d   = (state_d == P2);
        gwe_d   = (state_d == P3);
        phase_d = 2'd0;
        case (state_d)
            P1:      phase_d = 2'd1;
            P2:      phase_d = 2'd2;
            P3:      phase_d = 2'd3;
            default: phase_d = 2'd0;
        endcase

        a_gnt_d     = arb_edge & sel_valid & ~sel_b;
        b_gnt_d     = arb_edge & sel_valid & sel_b;
        dwe_d       = arb_edge & sel_valid & sel_we & ~sel_bad;
        addr_d      = (arb_edge & sel_valid) ? sel_addr  : addr_q;
        din_d       = (arb_edge & sel_valid) ? sel_wdata : din_q;
        prefer_a_d  = (arb_edge & sel_valid) ? sel_b     : prefer_a_q;

        win_valid_d = win_valid_q;
        win_b_d     = win_b_q;
        win_we_d    = win_we_q;
        win_bad_d   = win_bad_q;
        if (arb_edge) begin
            win_valid_d = sel_valid;
            win_b_d     = sel_b;
            win_we_d    = sel_we;
            win_bad_d   = sel_bad;
        end else if (ret_edge) begin
            win_valid_d = 1'b0;
        end

        // dout carries the P2 read during P3; unbacked addresses read as zero
        a_rvalid_d = ret_edge & win_valid_q & ~win_b_q & ~win_we_q;
        b_rvalid_d = ret_edge & win_valid_q & win_b_q & ~win_we_q;
        a_err_d    = ret_edge & win_valid_q & ~win_b_q & win_bad_q;
        b_err_d    = ret_edge & win_valid_q & win_b_q & win_bad_q;
        a_rdata_d  = a_rvalid_d ? (win_bad_q ? '0 : dout) : a_rdata_q;
        b_rdata_d  = b_rvalid_d ? (win_bad_q ? '0 : dout) : b_rdata_q;
    end

    assign i1re     = i1re_q;
    assign i2re     = i2re_q;
    assign dre      = dre_q;
    assign gwe      = gwe_q;
    assign phase    = phase_q;
    assign a_gnt    = a_gnt_q;
    assign b_gnt    = b_gnt_q;
    assign draddr   = addr_q;
    assign dwaddr   = addr_q;
    assign din      = din_q;
    assign dwe      = dwe_q;
    assign a_rvalid = a_rvalid_q;
    assign b_rvalid = b_rvalid_q;
    assign a_err    = a_err_q;
    assign b_err    = b_err_q;
    assign a_rdata  = a_rdata_q;
    assign b_rdata  = b_rdata_q;

endmodule

// File: doc/bram_access_sched.md
Name: bram_access_sched

Overview:
- Frame sequencer and data-port arbiter for the time-multiplexed block RAM.
- Generates the repeating 4-phase strobe frame on idclk:
  - phase 0: i1re (instruction fetch 1)
  - phase 1: i2re (instruction fetch 2)
  - phase 2: dre (data access)
  - phase 3: gwe (global write enable)
- Shares the single data slot per frame between two requesters: A (core) and B (host/debug loader).
- Handles request/grant handshake, address checking and read-return timing.

Parameters:
- WORD_SIZE, 16, width of data words on din/dout and requester data buses.

Ports:
- idclk  in  1  system clock; all state changes on rising edge.
- rst  in  1  synchronous, active-low reset.
- run  in  1  frame enable; 0 parks the sequencer in IDLE at the next frame boundary.
- a_req / b_req  in  1  data access request; held until the matching gnt.
- a_we / b_we  in  1  1 = write, 0 = read; stable while req is high.
- a_addr / b_addr  in  3  data word address.
- a_wdata / b_wdata  in  WORD_SIZE  write data.
- a_gnt / b_gnt  out  1  one-cycle grant pulse in the phase-2 cycle.
- a_rvalid / b_rvalid  out  1  one-cycle read-return pulse.
- a_rdata / b_rdata  out  WORD_SIZE  read data; held until the next rvalid for that requester.
- a_err / b_err  out  1  one-cycle pulse flagging an invalid address.
- i1re, i2re, dre, gwe  out  1  phase strobes to the RAM.
- draddr, dwaddr  out  3  RAM data read/write address; same value.
- din  out  WORD_SIZE  RAM write data.
- dwe  out  1  RAM data write enable.
- dout  in  WORD_SIZE  RAM data output; valid the cycle after dre.
- phase  out  2  current phase, for debug.

Behaviour:
- Reset (rst=0 at a clock edge):
  - state = IDLE.
  - All outputs 0, including rdata registers.
  - Pending winner and pending return are dropped.
  - Round-robin pointer set to favour A.
  - Reset asserted mid-frame aborts the frame immediately; no strobe, gnt or rvalid follows.
- State machine: IDLE, P0, P1, P2, P3.
  - IDLE -> P0 when run=1; otherwise stay.
  - P0 -> P1 -> P2 -> P3 unconditionally.
  - P3 -> P0 if run=1, else IDLE.
  - run is only examined in IDLE and P3; a frame always completes once started.
- Strobes are registered and one-hot:
  - i1re=1 in P0, i2re=1 in P1, dre=1 in P2, gwe=1 in P3.
  - All strobes are 0 in IDLE.
  - phase reports 0..3 in P0..P3 and 0 in IDLE.
- dre pulses in every P2 even with no winner. The RAM uses dre as the latched copy of i2re, so this pulse is mandatory.
- Arbitration, on the P1->P2 edge:
  - Sample a_req and b_req.
  - If only one is high, it wins.
  - If both are high, the requester not granted last wins; after reset A wins the first tie.
  - The pointer updates only on contended or uncontended grants, never on idle frames.
- During P2:
  - winner's gnt = 1.
  - draddr = dwaddr = winner addr.
  - din = winner wdata.
  - dwe = winner we AND address valid.
  - With no winner, dwe=0 and addresses/din hold their previous values.
  - Requests arriving after the P1 edge wait for the next frame.
  - The requester drops req, or presents a new request, in the cycle after gnt.
- Valid addresses are 2..7. Addresses 0 and 1 are unbacked:
  - the access is granted normally;
  - dwe is forced to 0;
  - a read returns rdata = 0;
  - err pulses with rvalid timing, for both reads and writes.
- Read return:
  - On the P3->next edge, capture dout (or 0 if the address is invalid) into the winner's rdata.
  - The winner's rvalid pulses in the following cycle (next P0, or IDLE).
  - Latency is gnt at cycle T -> rvalid at T+2.
  - This pulse is still emitted if run dropped and the state went to IDLE.
- Writes produce no rvalid.
- Throughput: at most one data access per 4-cycle frame. Two continuous requesters alternate A, B, A, B.

Test Plan:
- Reset, then run=1 for 12 cycles -> strobes i1re, i2re, dre, gwe repeat every 4 cycles, exactly one high per cycle; with no requests dre still pulses and dwe=0.
- A write addr 3 data 16'hBEEF, then A read addr 3 -> write: a_gnt with dwe=1, dwaddr=3, din=16'hBEEF; read: a_rvalid 2 cycles after a_gnt with a_rdata=16'hBEEF (RAM model in bench).
- A and B request reads continuously for 4 frames -> grants in order A, B, A, B; each rvalid is routed to the correct requester only.
- B writes addr 1 -> b_gnt pulses, dwe stays 0, b_err pulses 2 cycles after b_gnt; a B read of addr 0 returns b_rdata=0 with b_err=1.
- run dropped during P1 -> frame finishes through P3, state goes IDLE, a pending read rvalid still pulses once; run reasserted -> restart at P0.
- rst asserted in P2 with A granted -> next cycle all outputs 0, no rvalid ever issued for that access; after release the first contended tie goes to A.
